pipe_alu_param: RTL and testbench

Parametrised successor to the team's 4-stage pipelined register-bank ALU. It moves from two-phase clocks to a single clock and adds operand forwarding (no RAW stalls), per-instruction valid tracking, status flags, a host register-load port and a memory readback port. Each instruction reads two registers, computes, writes the result back to a register, and stores it to data memory. It sits between the instruction source and the data memory.

---
 rtl/pipe_alu_param.sv | 213 +++++++++++++++++++++
 tb/tb_pipe_alu_param.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_alu_param.sv
// pipe_alu_param: parametrised 4-stage register-bank ALU.
// Each instruction reads two registers (with full forwarding), computes,
// writes its result back to the bank, then stores it to data memory and
// presents it on y with status flags. One instruction per cycle, no stalls.

module pipe_alu_param #(
    parameter int DW = 16,
    parameter int RA = 4,
    parameter int MA = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [RA-1:0] rs1,
    input  logic [RA-1:0] rs2,
    input  logic [RA-1:0] rd,
    input  logic [MA-1:0] addr,
    input  logic [3:0]    func,
    input  logic          rf_we,
    input  logic [RA-1:0] rf_waddr,
    input  logic [DW-1:0] rf_wdata,
    input  logic [MA-1:0] mem_raddr,
    output logic [DW-1:0] mem_rdata,
    output logic [DW-1:0] y,
    output logic          y_valid,
    output logic          flag_z,
    output logic          flag_c,
    output logic          flag_n,
    output logic          flag_ill
);

    localparam int SW = (DW > 1) ? $clog2(DW) : 1;
    localparam int NR = 2 ** RA;
    localparam int NM = 2 ** MA;

    localparam logic [3:0] F_ADD  = 4'd0;
    localparam logic [3:0] F_SUB  = 4'd1;
    localparam logic [3:0] F_MUL  = 4'd2;
    localparam logic [3:0] F_AND  = 4'd3;
    localparam logic [3:0] F_OR   = 4'd4;
    localparam logic [3:0] F_XOR  = 4'd5;
    localparam logic [3:0] F_NAND = 4'd6;
    localparam logic [3:0] F_NOR  = 4'd7;
    localparam logic [3:0] F_NOT  = 4'd8;
    localparam logic [3:0] F_NEG  = 4'd9;
    localparam logic [3:0] F_SRL  = 4'd10;
    localparam logic [3:0] F_SLL  = 4'd11;
    localparam logic [3:0] F_SRA  = 4'd12;
    localparam logic [3:0] F_SLT  = 4'd13;
    localparam logic [3:0] F_PASS = 4'd14;

    logic [DW-1:0] regs [NR];
    logic [DW-1:0] mem  [NM];

    // S1 registers: forwarded operands and instruction fields
    logic          s1_valid;
    logic [DW-1:0] s1_a, s1_b;
    logic [RA-1:0] s1_rd;
    logic [MA-1:0] s1_addr;
    logic [3:0]    s1_func;

    // S2 registers: ALU result and flags {z, c, n, ill}
    logic          s2_valid;
    logic [DW-1:0] s2_res;
    logic [RA-1:0] s2_rd;
    logic [MA-1:0] s2_addr;
    logic [3:0]    s2_flags;

    // S3 registers: result on its way to memory and the output port
    logic          s3_valid;
    logic [DW-1:0] s3_res;
    logic [MA-1:0] s3_addr;
    logic [3:0]    s3_flags;

    logic [DW-1:0] alu_res;
    logic          alu_c, alu_ill;
    logic [DW:0]   sum_w, diff_w, neg_w;
    logic [DW-1:0] fwd_a, fwd_b;

    // ALU on the S1 registers; carry/borrow come from a DW+1 bit extension
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_ill = 1'b0;
        sum_w   = {1'b0, s1_a} + {1'b0, s1_b};
        diff_w  = {1'b0, s1_a} - {1'b0, s1_b};
        neg_w   = {(DW+1){1'b0}} - {1'b0, s1_a};
        case (s1_func)
            F_ADD:  begin alu_res = sum_w[DW-1:0];  alu_c = sum_w[DW];  end
            F_SUB:  begin alu_res = diff_w[DW-1:0]; alu_c = diff_w[DW]; end
            F_MUL:  alu_res = s1_a * s1_b;
            F_AND:  alu_res = s1_a & s1_b;
            F_OR:   alu_res = s1_a | s1_b;
            F_XOR:  alu_res = s1_a ^ s1_b;
            F_NAND: alu_res = ~(s1_a & s1_b);
            F_NOR:  alu_res = ~(s1_a | s1_b);
            F_NOT:  alu_res = ~s1_a;
            F_NEG:  begin alu_res = neg_w[DW-1:0]; alu_c = neg_w[DW]; end
            F_SRL:  begin alu_res = {1'b0, s1_a[DW-1:1]}; alu_c = s1_a[0]; end
            F_SLL:  begin alu_res = {s1_a[DW-2:0], 1'b0}; alu_c = s1_a[DW-1]; end
            F_SRA:  alu_res = $signed(s1_a) >>> s1_b[SW-1:0];
            F_SLT:  alu_res = {{(DW-1){1'b0}}, ($signed(s1_a) < $signed(s1_b))};
            F_PASS: alu_res = s1_b;
            default: alu_ill = 1'b1;
        endcase
    end

    // Operand forwarding: the instruction one ahead (live ALU) beats the one two ahead
    always_comb begin
        fwd_a = regs[rs1];
        fwd_b = regs[rs2];
        if (s2_valid && s2_rd == rs1) fwd_a = s2_res;
        if (s2_valid && s2_rd == rs2) fwd_b = s2_res;
        if (s1_valid && s1_rd == rs1) fwd_a = alu_res;
        if (s1_valid && s1_rd == rs2) fwd_b = alu_res;
    end

    // S1: capture an incoming instruction with its forwarded operands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_rd    <= '0;
            s1_addr  <= '0;
            s1_func  <= '0;
        end else begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_a    <= fwd_a;
                s1_b    <= fwd_b;
                s1_rd   <= rd;
                s1_addr <= addr;
                s1_func <= func;
            end
        end
    end

    // S2: register the ALU result and its flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_res   <= '0;
            s2_rd    <= '0;
            s2_addr  <= '0;
            s2_flags <= '0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_res   <= alu_res;
                s2_rd    <= s1_rd;
                s2_addr  <= s1_addr;
                s2_flags <= {(alu_res == '0), alu_c, alu_res[DW-1], alu_ill};
            end
        end
    end

    // S3 pipeline register carrying the result toward memory and y
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3_valid <= 1'b0;
            s3_res   <= '0;
            s3_addr  <= '0;
            s3_flags <= '0;
        end else begin
            s3_valid <= s2_valid;
            if (s2_valid) begin
                s3_res   <= s2_res;
                s3_addr  <= s2_addr;
                s3_flags <= s2_flags;
            end
        end
    end

    // Register bank: host write first so a same-edge pipeline writeback overrides it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NR; i++) regs[i] <= '0;
        end else begin
            if (rf_we) regs[rf_waddr] <= rf_wdata;
            if (s2_valid) regs[s2_rd] <= s2_res;
        end
    end

    // Data memory store from S4; memory contents survive reset
    always_ff @(posedge clk) begin
        if (s3_valid) mem[s3_addr] <= s3_res;
    end

    assign mem_rdata = mem[mem_raddr];

    // Retire: y and flags hold between instructions, y_valid pulses per retire
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y        <= '0;
            y_valid  <= 1'b0;
            flag_z   <= 1'b0;
            flag_c   <= 1'b0;
            flag_n   <= 1'b0;
            flag_ill <= 1'b0;
        end else begin
            y_valid <= s3_valid;
            if (s3_valid) begin
                y        <= s3_res;
                flag_z   <= s3_flags[3];
                flag_c   <= s3_flags[2];
                flag_n   <= s3_flags[1];
                flag_ill <= s3_flags[0];
            end
        end
    end

endmodule

// File: tb/tb_pipe_alu_param.sv
// tb_pipe_alu_param: directed vectors with hand-computed results; a scoreboard
// queue holds expected retirements and a monitor compares each y_valid cycle.

module tb_pipe_alu_param;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid = 1'b0;
    logic [3:0]  rs1 = '0, rs2 = '0, rd = '0, func = '0;
    logic [7:0]  addr = '0;
    logic        rf_we = 1'b0;
    logic [3:0]  rf_waddr = '0;
    logic [15:0] rf_wdata = '0;
    logic [7:0]  mem_raddr = '0;
    logic [15:0] mem_rdata, y;
    logic        y_valid, flag_z, flag_c, flag_n, flag_ill;

    typedef struct {
        logic [15:0] y;
        logic [3:0]  flags;
        int          due;
        string       name;
    } exp_t;

    exp_t sbq[$];
    int   cyc = 0;
    int   nChecks = 0;
    int   nPass = 0;

    pipe_alu_param #(.DW(16), .RA(4), .MA(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .rs1(rs1), .rs2(rs2), .rd(rd), .addr(addr), .func(func),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
        .y(y), .y_valid(y_valid),
        .flag_z(flag_z), .flag_c(flag_c), .flag_n(flag_n), .flag_ill(flag_ill)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("[TB] FAIL %s: got %0h, want %0h", nm, act, exp);
    endtask

    task automatic issueRaw(input logic [3:0] f, input logic [3:0] a1, input logic [3:0] a2,
                            input logic [3:0] d, input logic [7:0] ma);
        @(negedge clk);
        in_valid = 1'b1;
        rf_we    = 1'b0;
        func     = f;
        rs1      = a1;
        rs2      = a2;
        rd       = d;
        addr     = ma;
    endtask

    task automatic applyStimulus(input logic [3:0] f, input logic [3:0] a1, input logic [3:0] a2,
                                 input logic [3:0] d, input logic [7:0] ma,
                                 input logic [15:0] ey, input logic ec, input string nm);
        exp_t e;
        issueRaw(f, a1, a2, d, ma);
        e.y     = ey;
        e.flags = {(ey == 16'h0), ec, ey[15], (f == 4'd15)};
        e.due   = cyc + 4;
        e.name  = nm;
        sbq.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            rf_we    = 1'b0;
        end
    endtask

    task automatic hostWrite(input logic [3:0] a, input logic [15:0] d);
        @(negedge clk);
        in_valid = 1'b0;
        rf_we    = 1'b1;
        rf_waddr = a;
        rf_wdata = d;
    endtask

    task automatic drain();
        for (int i = 0; i < 20; i++) begin
            idle(1);
            if (sbq.size() == 0) break;
        end
        checkOutput("drain_queue_empty", sbq.size(), 0);
    endtask

    task automatic checkMem(input logic [7:0] a, input logic [15:0] ev, input string nm);
        @(negedge clk);
        mem_raddr = a;
        #1;
        checkOutput(nm, mem_rdata, ev);
    endtask

    // Monitor: every retiring instruction is matched against the scoreboard head
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (y_valid) begin
                if (sbq.size() == 0) begin
                    nChecks++;
                    $display("[TB] FAIL unexpected_retire: got y=%0h, want no retirement", y);
                end else begin
                    e = sbq.pop_front();
                    checkOutput({e.name, "_y"}, y, e.y);
                    checkOutput({e.name, "_flags"}, {flag_z, flag_c, flag_n, flag_ill}, e.flags);
                    checkOutput({e.name, "_latency"}, cyc, e.due);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_y", y, 0);
        checkOutput("reset_y_valid", y_valid, 0);
        checkOutput("reset_flags", {flag_z, flag_c, flag_n, flag_ill}, 0);
        rst_n = 1'b1;

        for (int k = 0; k < 16; k++) hostWrite(4'(k), 16'(k));

        applyStimulus(4'd0, 4'd7, 4'd3, 4'd10, 8'd100, 16'd10, 1'b0, "add");
        applyStimulus(4'd1, 4'd7, 4'd3, 4'd11, 8'd101, 16'd4,  1'b0, "sub");
        applyStimulus(4'd2, 4'd7, 4'd3, 4'd12, 8'd102, 16'd21, 1'b0, "mul");
        applyStimulus(4'd3, 4'd7, 4'd3, 4'd13, 8'd103, 16'd3,  1'b0, "and");
        applyStimulus(4'd4, 4'd7, 4'd3, 4'd14, 8'd104, 16'd7,  1'b0, "or");
        applyStimulus(4'd5, 4'd7, 4'd3, 4'd15, 8'd105, 16'd4,  1'b0, "xor");
        drain();
        checkMem(8'd100, 16'd10, "mem100");
        checkMem(8'd101, 16'd4,  "mem101");
        checkMem(8'd102, 16'd21, "mem102");
        checkMem(8'd103, 16'd3,  "mem103");
        checkMem(8'd104, 16'd7,  "mem104");
        checkMem(8'd105, 16'd4,  "mem105");

        for (int gap = 0; gap < 3; gap++) begin
            hostWrite(4'd10, 16'd0);
            hostWrite(4'd11, 16'd0);
            applyStimulus(4'd0, 4'd7, 4'd3, 4'd10, 8'd106, 16'd10, 1'b0, "chain_head");
            idle(gap);
            applyStimulus(4'd0, 4'd10, 4'd1, 4'd11, 8'd107, 16'd11, 1'b0,
                          (gap == 0) ? "fwd_dist1" : (gap == 1) ? "fwd_dist2" : "bank_read");
            drain();
        end

        hostWrite(4'd1, 16'hFFFF);
        hostWrite(4'd2, 16'd1);
        applyStimulus(4'd0,  4'd1, 4'd2, 4'd5, 8'd120, 16'h0000, 1'b1, "add_wrap");
        applyStimulus(4'd1,  4'd2, 4'd1, 4'd5, 8'd121, 16'h0002, 1'b1, "sub_borrow");
        applyStimulus(4'd15, 4'd7, 4'd3, 4'd5, 8'd122, 16'h0000, 1'b0, "illegal");
        applyStimulus(4'd6,  4'd7, 4'd3, 4'd6, 8'd130, 16'hFFFC, 1'b0, "nand");
        applyStimulus(4'd7,  4'd7, 4'd3, 4'd6, 8'd131, 16'hFFF8, 1'b0, "nor");
        applyStimulus(4'd8,  4'd7, 4'd3, 4'd6, 8'd132, 16'hFFF8, 1'b0, "not");
        applyStimulus(4'd12, 4'd6, 4'd2, 4'd9, 8'd133, 16'hFFFC, 1'b0, "sra_neg_fwd");
        applyStimulus(4'd12, 4'd8, 4'd3, 4'd6, 8'd134, 16'h0001, 1'b0, "sra_pos");
        applyStimulus(4'd9,  4'd7, 4'd3, 4'd6, 8'd135, 16'hFFF9, 1'b1, "neg");
        applyStimulus(4'd10, 4'd7, 4'd3, 4'd6, 8'd136, 16'h0003, 1'b1, "srl");
        applyStimulus(4'd11, 4'd1, 4'd3, 4'd6, 8'd137, 16'hFFFE, 1'b1, "sll");
        applyStimulus(4'd13, 4'd1, 4'd3, 4'd6, 8'd138, 16'h0001, 1'b0, "slt_true");
        applyStimulus(4'd13, 4'd7, 4'd3, 4'd6, 8'd139, 16'h0000, 1'b0, "slt_false");
        applyStimulus(4'd2,  4'd1, 4'd3, 4'd6, 8'd140, 16'hFFFD, 1'b0, "mul_wrap");
        applyStimulus(4'd14, 4'd0, 4'd3, 4'd6, 8'd141, 16'h0003, 1'b0, "pass");
        drain();

        hostWrite(4'd9, 16'd9);
        applyStimulus(4'd0, 4'd7, 4'd3, 4'd10, 8'd142, 16'd10, 1'b0, "wb_vs_host");
        idle(1);
        hostWrite(4'd10, 16'h0055);
        drain();
        applyStimulus(4'd14, 4'd0, 4'd10, 4'd6, 8'd143, 16'd10, 1'b0, "r10_after_collision");
        applyStimulus(4'd14, 4'd0, 4'd9, 4'd6, 8'd144, 16'd9, 1'b0, "host_not_forwarded");
        rf_we    = 1'b1;
        rf_waddr = 4'd9;
        rf_wdata = 16'h0077;
        applyStimulus(4'd14, 4'd0, 4'd9, 4'd6, 8'd145, 16'h0077, 1'b0, "host_visible_next");
        drain();

        issueRaw(4'd14, 4'd0, 4'd7, 4'd10, 8'd120);
        issueRaw(4'd14, 4'd0, 4'd7, 4'd10, 8'd121);
        issueRaw(4'd14, 4'd0, 4'd7, 4'd10, 8'd122);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("midreset_y", y, 0);
        checkOutput("midreset_y_valid", y_valid, 0);
        checkOutput("midreset_flags", {flag_z, flag_c, flag_n, flag_ill}, 0);
        rst_n = 1'b1;
        checkMem(8'd120, 16'h0000, "mem120_kept");
        checkMem(8'd121, 16'h0002, "mem121_kept");
        checkMem(8'd122, 16'h0000, "mem122_kept");
        applyStimulus(4'd14, 4'd0, 4'd10, 4'd6, 8'd150, 16'h0000, 1'b0, "r10_cleared");
        applyStimulus(4'd14, 4'd0, 4'd7, 4'd6, 8'd151, 16'h0000, 1'b0, "r7_cleared");
        drain();

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
